// File: rtl/traffic_pkg.sv
// traffic_pkg: state encoding, lamp patterns and a constant helper for traffic_light_ctrl
package traffic_pkg;
    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALLRED_A    = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALLRED_B    = 3'd5,
        WALK        = 3'd6
    } tl_state_t;
    localparam logic [2:0] LT_RED = 3'b100;
    localparam logic [2:0] LT_YEL = 3'b010;
    localparam logic [2:0] LT_GRN = 3'b001;
    function automatic int max_int(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/tl_phase_timer.sv
// tl_phase_timer: prescaled tick counter; done when dur ticks have fully elapsed, held by saturation
module tl_phase_timer #(
    parameter int TICK_DIV = 1,
    parameter int DUR_W    = 3
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [DUR_W-1:0] dur,
    output logic             done
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    logic [PW-1:0]    presc_d, presc_q;
    logic [DUR_W-1:0] tick_d, tick_q;
    logic             wrap, sat;
    always_comb begin
        wrap    = presc_q == PW'(TICK_DIV - 1);
        sat     = tick_q == dur;
        presc_d = (clear || wrap) ? '0 : presc_q + 1'b1;
        tick_d  = clear ? '0 : (wrap && !sat) ? tick_q + 1'b1 : tick_q;
        // last cycle of the final tick, or already saturated (only reachable while waiting in main green)
        done    = sat || (wrap && tick_q == dur - 1'b1);
    end
    always_ff @(posedge clk) begin
        presc_q <= presc_d;
        tick_q  <= tick_d;
    end
endmodule

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: timed two-road intersection controller with request latches.
// Define TRAFFIC_PED_EN to build the pedestrian request latch and WALK phase.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int TICK_DIV = 1,
    parameter int GREEN_T  = 4,
    parameter int SIDE_T   = 3,
    parameter int YELLOW_T = 2,
    parameter int ALLRED_T = 1,
    parameter int WALK_T   = 3
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       sensor,
    input  logic       ped_req,
    output logic [2:0] main_lt,
    output logic [2:0] side_lt,
    output logic       walk,
    output logic [2:0] phase
);
    localparam int MAX_T = max_int(max_int(max_int(GREEN_T, SIDE_T), max_int(YELLOW_T, ALLRED_T)), WALK_T);
    localparam int DW    = $clog2(MAX_T + 1);
    tl_state_t     state_d, state_q;
    logic          side_pend_d, side_pend_q, ped_pend_q;
    logic          done, clear;
    logic [DW-1:0] dur;
`ifdef TRAFFIC_PED_EN
    localparam bit PED_EN = 1'b1;
    logic ped_pend_d;
    always_comb ped_pend_d = !RESET && !(state_d == WALK && state_q != WALK) && (ped_pend_q || (ped_req && state_q != WALK));
    always_ff @(posedge clk) ped_pend_q <= ped_pend_d;
    assign walk = state_q == WALK;
`else
    localparam bit PED_EN = 1'b0;
    logic ped_unused;
    assign ped_unused = ped_req;
    assign ped_pend_q = 1'b0;
    assign walk       = 1'b0;
`endif
    tl_phase_timer #(.TICK_DIV(TICK_DIV), .DUR_W(DW)) u_timer (
        .clk  (clk),
        .clear(clear),
        .dur  (dur),
        .done (done)
    );
    always_comb begin
        state_d = state_q;
        dur     = DW'(GREEN_T);
        case (state_q)
            MAIN_GREEN:  state_d = (done && (side_pend_q || ped_pend_q)) ? MAIN_YELLOW : MAIN_GREEN;
            MAIN_YELLOW: begin
                dur     = DW'(YELLOW_T);
                state_d = done ? ALLRED_A : MAIN_YELLOW;
            end
            ALLRED_A: begin
                dur     = DW'(ALLRED_T);
                state_d = !done ? ALLRED_A : (side_pend_q || !PED_EN) ? SIDE_GREEN : WALK;
            end
            SIDE_GREEN: begin
                dur     = DW'(SIDE_T);
                state_d = done ? SIDE_YELLOW : SIDE_GREEN;
            end
            SIDE_YELLOW: begin
                dur     = DW'(YELLOW_T);
                state_d = done ? ALLRED_B : SIDE_YELLOW;
            end
            ALLRED_B: begin
                dur     = DW'(ALLRED_T);
                state_d = !done ? ALLRED_B : ped_pend_q ? WALK : MAIN_GREEN;
            end
            WALK: begin
                dur     = DW'(WALK_T);
                state_d = done ? MAIN_GREEN : WALK;
            end
            default: state_d = MAIN_GREEN;
        endcase
        if (RESET) state_d = MAIN_GREEN;
        clear       = RESET || state_d != state_q;
        // entry into side green clears the latch even if the sensor is still high
        side_pend_d = !RESET && !(state_d == SIDE_GREEN && state_q != SIDE_GREEN)
                      && (side_pend_q || (sensor && state_q != SIDE_GREEN && state_q != SIDE_YELLOW));
    end
    always_ff @(posedge clk) begin
        state_q     <= state_d;
        side_pend_q <= side_pend_d;
    end
    assign main_lt = state_q == MAIN_GREEN ? LT_GRN : state_q == MAIN_YELLOW ? LT_YEL : LT_RED;
    assign side_lt = state_q == SIDE_GREEN ? LT_GRN : state_q == SIDE_YELLOW ? LT_YEL : LT_RED;
    assign phase   = state_q;
endmodule
